// File: rtl/pc_unit.sv
// Program counter stage: next-PC select, trap vectors, supervisor mode.
// Drives the fetch address and the $k0 return value on trap entry.
module pc_unit #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSrc,
  input  logic        BranchTaken,
  input  logic [15:0] Imm16,
  input  logic [25:0] JumpTarget,
  input  logic [31:0] RegTarget,
  input  logic        Undefined,
  input  logic        TimerIrq,
  input  logic        UartIrq,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        Supervisor,
  output logic        TrapTake,
  output logic [31:0] KReturn,
  output logic        IrqPending,
  output logic [31:0] InstCount
);

  logic [31:0] pc_q;
  logic [31:0] icount_q;
  logic        pend_q;
  logic [31:0] seq;
  logic [31:0] br_sum;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] r_tgt;
  logic [31:0] pc_next;
  logic        uart_req;
  logic        irq;
  logic        exc;
  logic        uart_clr;
  logic        pend_next;

  // increment stays inside the current mode half of the space
  assign seq    = {pc_q[31], pc_q[30:0] + 31'd4};
  assign br_sum = seq + {{14{Imm16[15]}}, Imm16, 2'b00};
  assign br_tgt = {pc_q[31], br_sum[30:0]};
  assign j_tgt  = {pc_q[31], seq[30:28], JumpTarget, 2'b00};
  assign r_tgt  = {pc_q[31] & RegTarget[31], RegTarget[30:0]};

  assign uart_req = pend_q | UartIrq;
  assign irq      = (TimerIrq | uart_req) & ~pc_q[31];
  assign exc      = Undefined & ~pc_q[31] & ~irq;
  // timer outranks uart; a uart taken behind it stays latched
  assign uart_clr = irq & ~TimerIrq;
  // a fresh pulse on top of a latched cause being serviced survives
  assign pend_next = uart_clr ? (pend_q & UartIrq)
                              : (pend_q | UartIrq);

  always_comb begin
    pc_next = seq;
    unique case (1'b1)
      irq: pc_next = IRQ_VEC;
      exc: pc_next = EXC_VEC;
      default: begin
        case (PCSrc)
          2'd0: pc_next = seq;
          2'd1: pc_next = BranchTaken ? br_tgt : seq;
          2'd2: pc_next = j_tgt;
          2'd3: pc_next = r_tgt;
          default: pc_next = seq;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_VEC;
      pend_q   <= 1'b0;
      icount_q <= 32'd0;
    end else begin
      pc_q   <= pc_next;
      pend_q <= pend_next;
      if (!(irq | exc))
        icount_q <= icount_q + 32'd1;
    end
  end

  assign PC         = pc_q;
  assign PCPlus4    = seq;
  assign Supervisor = pc_q[31];
  assign TrapTake   = irq | exc;
  assign KReturn    = irq ? pc_q : {1'b0, seq[30:0]};
  assign IrqPending = pend_q;
  assign InstCount  = icount_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table plus trap/reset sequences.
// Expected post-edge state flows through a queue scoreboard.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  PCSrc = 2'd0;
  logic        BranchTaken = 1'b0;
  logic [15:0] Imm16 = 16'd0;
  logic [25:0] JumpTarget = 26'd0;
  logic [31:0] RegTarget = 32'd0;
  logic        Undefined = 1'b0;
  logic        TimerIrq = 1'b0;
  logic        UartIrq = 1'b0;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Supervisor;
  logic        TrapTake;
  logic [31:0] KReturn;
  logic        IrqPending;
  logic [31:0] InstCount;

  int compared = 0;
  int mismatched = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc),
    .BranchTaken(BranchTaken), .Imm16(Imm16),
    .JumpTarget(JumpTarget), .RegTarget(RegTarget),
    .Undefined(Undefined), .TimerIrq(TimerIrq),
    .UartIrq(UartIrq), .PC(PC), .PCPlus4(PCPlus4),
    .Supervisor(Supervisor), .TrapTake(TrapTake),
    .KReturn(KReturn), .IrqPending(IrqPending),
    .InstCount(InstCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pre;
    logic [1:0]  src;
    logic        bt;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] rt;
    logic        und;
    logic        tmr;
    logic        uart;
    logic        trap;
    logic [31:0] kret;
    logic [31:0] npc;
    logic        pend;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        sup;
    logic [31:0] icnt;
    logic        pend;
  } exp_t;

  vec_t vt[14];
  exp_t exp_q[$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic clear_in();
    PCSrc = 2'd0; BranchTaken = 1'b0; Imm16 = 16'd0;
    JumpTarget = 26'd0; RegTarget = 32'd0;
    Undefined = 1'b0; TimerIrq = 1'b0; UartIrq = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // pop one expectation and compare the registered state
  task automatic check_state();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk($sformatf("v%0d_pc", e.id), PC, e.pc);
    chk($sformatf("v%0d_sup", e.id), {31'd0, Supervisor}, {31'd0, e.sup});
    chk($sformatf("v%0d_icnt", e.id), InstCount, e.icnt);
    chk($sformatf("v%0d_pend", e.id), {31'd0, IrqPending}, {31'd0, e.pend});
  endtask

  // reset, then one register jump from supervisor mode to the start PC
  task automatic set_pc(input logic [31:0] pre);
    clear_in();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    PCSrc = 2'd3;
    RegTarget = pre;
    step();
    clear_in();
  endtask

  initial begin
    vt[0]  = '{32'h0000_0068, 2'd1, 1'b1, 16'hFFE0, 26'd0, 32'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h7FFF_FFEC, 1'b0};
    vt[1]  = '{32'h0000_0068, 2'd1, 1'b0, 16'hFFE0, 26'd0, 32'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_006C, 1'b0};
    vt[2]  = '{32'h8000_0040, 2'd3, 1'b0, 16'd0, 26'd0, 32'h0000_0044,
               1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0044, 1'b0};
    vt[3]  = '{32'h0000_0030, 2'd3, 1'b0, 16'd0, 26'd0, 32'h8000_0010,
               1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0010, 1'b0};
    vt[4]  = '{32'h0000_00D8, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0,
               1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_00D8, 32'h8000_0004, 1'b0};
    vt[5]  = '{32'h0000_0100, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0,
               1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h8000_0004, 1'b0};
    vt[6]  = '{32'h0000_0020, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0,
               1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0024, 32'h8000_0008, 1'b0};
    vt[7]  = '{32'h8000_0050, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0,
               1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h8000_0054, 1'b0};
    vt[8]  = '{32'h0FFF_FFFC, 2'd2, 1'b0, 16'd0, 26'h000_0010, 32'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h1000_0040, 1'b0};
    vt[9]  = '{32'h7FFF_FFFC, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h0000_0000, 1'b0};
    vt[10] = '{32'hFFFF_FFFC, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 1'b0};
    vt[11] = '{32'h8000_0000, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0,
               1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'h8000_0004, 1'b0};
    vt[12] = '{32'h8000_0020, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0,
               1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h8000_0024, 1'b1};
    vt[13] = '{32'h0000_0200, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0,
               1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h8000_0004, 1'b1};

    @(negedge clk);
    reset = 1'b1;
    #2;
    chk("rst_pc", PC, 32'h8000_0000);
    chk("rst_icnt", InstCount, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 14; i++) begin
      set_pc(vt[i].pre);
      chk($sformatf("v%0d_prepc", i), PC, vt[i].pre);
      PCSrc = vt[i].src;
      BranchTaken = vt[i].bt;
      Imm16 = vt[i].imm;
      JumpTarget = vt[i].jt;
      RegTarget = vt[i].rt;
      Undefined = vt[i].und;
      TimerIrq = vt[i].tmr;
      UartIrq = vt[i].uart;
      #1;
      chk($sformatf("v%0d_trap", i), {31'd0, TrapTake}, {31'd0, vt[i].trap});
      if (vt[i].trap)
        chk($sformatf("v%0d_kret", i), KReturn, vt[i].kret);
      exp_q.push_back('{i, vt[i].npc, vt[i].npc[31],
                        vt[i].trap ? 32'd1 : 32'd2, vt[i].pend});
      step();
      check_state();
    end

    // timer held across the handler entry must not retrap
    set_pc(32'h0000_00D8);
    TimerIrq = 1'b1;
    #1;
    chk("tmr_trap", {31'd0, TrapTake}, 32'd1);
    exp_q.push_back('{100, 32'h8000_0004, 1'b1, 32'd1, 1'b0});
    step();
    check_state();
    #1;
    chk("tmr_masked", {31'd0, TrapTake}, 32'd0);
    exp_q.push_back('{101, 32'h8000_0008, 1'b1, 32'd2, 1'b0});
    step();
    check_state();

    // latched uart serviced once back in user mode
    set_pc(32'h8000_0020);
    UartIrq = 1'b1;
    exp_q.push_back('{102, 32'h8000_0024, 1'b1, 32'd2, 1'b1});
    step();
    check_state();
    clear_in();
    PCSrc = 2'd3;
    RegTarget = 32'h0000_0040;
    exp_q.push_back('{103, 32'h0000_0040, 1'b0, 32'd3, 1'b1});
    step();
    check_state();
    clear_in();
    UartIrq = 1'b1;
    #1;
    chk("pend_trap", {31'd0, TrapTake}, 32'd1);
    chk("pend_kret", KReturn, 32'h0000_0040);
    exp_q.push_back('{104, 32'h8000_0004, 1'b1, 32'd3, 1'b1});
    step();
    check_state();
    clear_in();

    // asynchronous reset mid-run with a pending request
    TimerIrq = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_pc", PC, 32'h8000_0000);
    chk("mid_rst_icnt", InstCount, 32'd0);
    chk("mid_rst_pend", {31'd0, IrqPending}, 32'd0);
    chk("mid_rst_pc4", PCPlus4, 32'h8000_0004);
    chk("mid_rst_sup", {31'd0, Supervisor}, 32'd1);
    chk("mid_rst_trap", {31'd0, TrapTake}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_in();
    exp_q.push_back('{105, 32'h8000_0004, 1'b1, 32'd1, 1'b0});
    step();
    check_state();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
